timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the period and load-value width.
REQ-002 Parameter REPEAT_W, default 8, SHALL set the repeat-count width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 cmd_valid  in  1  SHALL indicate a valid command.
REQ-006 cmd_ready  out  1  SHALL indicate a command is accepted this cycle if cmd_valid=1.
REQ-007 cmd_period  in  WIDTH  SHALL carry the countdown load value N.
REQ-008 cmd_repeat  in  REPEAT_W  SHALL carry the number of expiries R; 0 means free-running.
REQ-009 cmd_abort  in  1  SHALL request termination of the active command.
REQ-010 cnt_load_value  out  WIDTH  SHALL drive the down-counter load input.
REQ-011 cnt_mode  out  1  SHALL drive the down-counter mode: 0=load/hold, 1=count.
REQ-012 cnt_status  in  1  SHALL receive the down-counter zero status.
REQ-013 expire  out  1  SHALL pulse for one cycle per expiry.
REQ-014 last  out  1  SHALL qualify the final expire of a finite command.
REQ-015 busy  out  1  SHALL be 1 whenever a command is active.
REQ-016 remaining  out  REPEAT_W  SHALL show the expiries still outstanding.
REQ-017 irq  out  1  SHALL be the sticky expiry interrupt; irq_clear  in  1  SHALL clear it.

Function
REQ-018 States SHALL be IDLE, LOAD, ARM and RUN; all outputs SHALL be decoded from registers, with no combinational input-to-output path.
REQ-019 IDLE: cmd_ready=1, cnt_mode=0; on cmd_valid, N and R SHALL be captured, remaining<=R, and the next state SHALL be LOAD.
REQ-020 In LOAD, cnt_mode SHALL be 0 and cnt_load_value=N; next state SHALL be ARM.
REQ-021 In ARM, cnt_mode SHALL be 1, cnt_status SHALL be ignored (post-load status=1), and the next state SHALL be RUN.
REQ-022 In RUN, cnt_mode SHALL be 1, and cnt_status=1 SHALL assert expire that cycle.
- On expire with R=0, the next state SHALL be LOAD.
- On expire with remaining>1, remaining SHALL decrement and the next state SHALL be LOAD.
- On expire with remaining=1, last SHALL assert, remaining SHALL become 0, and the next state SHALL be IDLE.
REQ-023 With a counter obeying the load/count protocol, LOAD-to-LOAD and expire-to-expire spacing SHALL be N+3 cycles for all N including 0 and 2^WIDTH-1.
REQ-024 cnt_load_value SHALL hold the captured N from acceptance until the next acceptance; it SHALL be 0 after reset.
REQ-025 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE SHALL be ignored and not queued.
REQ-026 cmd_abort in LOAD, ARM or RUN SHALL force IDLE next cycle with remaining<=0 and no expire or last.
- If cmd_abort and cnt_status=1 coincide in RUN, abort SHALL win and expire SHALL be suppressed.
- cmd_abort in IDLE SHALL be ignored; a coincident cmd_valid SHALL be accepted.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 In free-running mode, remaining SHALL stay 0.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE and SHALL set cnt_mode=0, cnt_load_value=0, expire=0, last=0, remaining=0, irq=0 and busy=0; cmd_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-030 Reset SHALL override any in-flight command and any simultaneous cmd_valid, cmd_abort or cnt_status without generating an expire.

Configuration
REQ-031 When macro TIMER_CTRL_IRQ_EN is defined, irq SHALL set on every expire and clear on irq_clear.
- If irq_clear and expire coincide, set SHALL win.
REQ-032 When TIMER_CTRL_IRQ_EN is undefined, irq SHALL be tied 0 and irq_clear ignored; ports SHALL remain present.

Verification
REQ-033 Command N=5, R=3, driving a counter model -> three expire pulses 8 cycles apart, last with the third, remaining 3->2->1->0, busy drops the cycle after the third expire.
REQ-034 Command N=0, R=0 -> expire every 3 cycles, remaining=0; cmd_abort -> IDLE next cycle, no further expire.
REQ-035 cmd_abort in the same cycle as cnt_status=1 in RUN -> no expire, IDLE next cycle, irq unchanged.
REQ-036 reset asserted mid-RUN with N=10 -> all outputs at reset values next cycle; new command N=2, R=1 -> single expire with last 5 cycles after LOAD.
REQ-037 With TIMER_CTRL_IRQ_EN defined, irq_clear coincident with expire -> irq stays 1; with the macro undefined -> irq stays 0 throughout.
REQ-038 cmd_valid held high during RUN with N=4, R=1 -> ignored until IDLE, then accepted with cmd_ready=1.

Source files
------------

// File: rtl/timer_ctrl.sv
// Repeating timer sequencer driving an external down-counter through a LOAD/ARM/RUN handshake.
// Optional sticky expiry interrupt enabled by defining TIMER_CTRL_IRQ_EN.
module timer_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REPEAT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [WIDTH-1:0]    cmd_period,
  input  logic [REPEAT_W-1:0] cmd_repeat,
  input  logic                cmd_abort,
  output logic [WIDTH-1:0]    cnt_load_value,
  output logic                cnt_mode,
  input  logic                cnt_status,
  output logic                expire,
  output logic                last,
  output logic                busy,
  output logic [REPEAT_W-1:0] remaining,
  output logic                irq,
  input  logic                irq_clear
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ARM  = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t              state, state_next;
  logic                free_run, free_next;
  logic [REPEAT_W-1:0] remaining_next;
  logic [WIDTH-1:0]    load_next;
  logic                expire_next, last_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      free_run       <= 1'b0;
      remaining      <= '0;
      cnt_load_value <= '0;
      expire         <= 1'b0;
      last           <= 1'b0;
    end else begin
      state          <= state_next;
      free_run       <= free_next;
      remaining      <= remaining_next;
      cnt_load_value <= load_next;
      expire         <= expire_next;
      last           <= last_next;
    end
  end

  // expire/last are registered: the pulse lands on the cycle the FSM re-enters LOAD (or IDLE)
  always_comb begin
    state_next     = state;
    free_next      = free_run;
    remaining_next = remaining;
    load_next      = cnt_load_value;
    expire_next    = 1'b0;
    last_next      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load_next      = cmd_period;
          remaining_next = cmd_repeat;
          free_next      = (cmd_repeat == '0);
          state_next     = LOAD;
        end
      end
      LOAD: begin
        if (cmd_abort) begin
          remaining_next = '0;
          state_next     = IDLE;
        end else begin
          state_next = ARM;
        end
      end
      ARM: begin
        if (cmd_abort) begin
          remaining_next = '0;
          state_next     = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (cmd_abort) begin
          remaining_next = '0;
          state_next     = IDLE;
        end else if (cnt_status) begin
          expire_next = 1'b1;
          if (free_run) begin
            state_next = LOAD;
          end else if (remaining > REPEAT_W'(1)) begin
            remaining_next = remaining - 1'b1;
            state_next     = LOAD;
          end else begin
            last_next      = 1'b1;
            remaining_next = '0;
            state_next     = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cnt_mode  = (state == ARM) || (state == RUN);

`ifdef TIMER_CTRL_IRQ_EN
  // sampling the registered expire lets a coincident irq_clear lose to the set
  always_ff @(posedge clk) begin
    if (reset)          irq <= 1'b0;
    else if (expire)    irq <= 1'b1;
    else if (irq_clear) irq <= 1'b0;
  end
`else
  logic unused_irq_clear;
  assign irq              = 1'b0;
  assign unused_irq_clear = irq_clear;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: directed commands queue expected expiries, a monitor checks them.
module tb_timer_ctrl;
  localparam int unsigned W  = 8;
  localparam int unsigned RW = 4;
`ifdef TIMER_CTRL_IRQ_EN
  localparam logic [31:0] IRQ_EXP = 32'd1;
`else
  localparam logic [31:0] IRQ_EXP = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          reset, cmd_valid, cmd_ready, cmd_abort;
  logic          cnt_mode, cnt_status, expire, last, busy, irq, irq_clear;
  logic [W-1:0]  cmd_period, cnt_load_value;
  logic [RW-1:0] cmd_repeat, remaining;
  logic [W-1:0]  cnt;
  int            cyc = 0;
  int            pass_cnt = 0;
  int            chk_cnt = 0;

  typedef struct {
    int cyc;
    bit lst;
    int rem;
  } exp_t;
  exp_t sb[$];

  timer_ctrl #(.WIDTH(W), .REPEAT_W(RW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_repeat(cmd_repeat), .cmd_abort(cmd_abort),
    .cnt_load_value(cnt_load_value), .cnt_mode(cnt_mode), .cnt_status(cnt_status),
    .expire(expire), .last(last), .busy(busy), .remaining(remaining),
    .irq(irq), .irq_clear(irq_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External down-counter: mode 0 loads, mode 1 counts to 0; zero status is registered
  always @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      cnt_status <= 1'b0;
    end else begin
      cnt_status <= (cnt == '0);
      if (!cnt_mode)      cnt <= cnt_load_value;
      else if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, exp);
  endtask

  task automatic push(input int c, input bit l, input int r);
    exp_t e;
    e.cyc = c;
    e.lst = l;
    e.rem = r;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && expire) begin
      if (sb.size() == 0) begin
        check("unexpected_expire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("expire_cycle", cyc, e.cyc);
        check("expire_last", {31'd0, last}, {31'd0, e.lst});
        check("expire_remaining", {28'd0, remaining}, e.rem);
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int n, input int r, output int l);
    for (int i = 0; i < 1000 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("ready_before_issue", cmd_ready, 1);
    cmd_period = W'(n);
    cmd_repeat = RW'(r);
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    l = cyc;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cnt_mode"}, cnt_mode, 0);
    check({tag, "_load_value"}, cnt_load_value, 0);
    check({tag, "_expire"}, expire, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_remaining"}, remaining, 0);
    check({tag, "_irq"}, irq, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    reset = 1'b1; cmd_valid = 1'b0; cmd_abort = 1'b0; irq_clear = 1'b0;
    cmd_period = '0; cmd_repeat = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("por_ready", cmd_ready, 1);

    // N=5 R=3: expiries 8 apart, irq clear vs. coincident expire
    issue(5, 3, l);
    push(l + 8, 1'b0, 2); push(l + 16, 1'b0, 1); push(l + 24, 1'b1, 0);
    check("t1_rem_loaded", remaining, 3);
    check("t1_load_value", cnt_load_value, 5);
    check("t1_load_mode", cnt_mode, 0);
    check("t1_ready_busy", cmd_ready, 0);
    wait_cyc(l + 1);
    check("t1_arm_mode", cnt_mode, 1);
    wait_cyc(l + 9);
    check("t1_irq_set", irq, IRQ_EXP);
    wait_cyc(l + 16); irq_clear = 1'b1;
    wait_cyc(l + 17); irq_clear = 1'b0;
    check("t1_irq_set_wins", irq, IRQ_EXP);
    wait_cyc(l + 18); irq_clear = 1'b1;
    wait_cyc(l + 19); irq_clear = 1'b0;
    check("t1_irq_cleared", irq, 0);
    wait_cyc(l + 25);
    check("t1_busy_done", busy, 0);
    check("t1_rem_done", remaining, 0);

    // N=0 free-running: expire every 3 cycles, then abort in ARM
    issue(0, 0, l);
    for (int k = 1; k <= 4; k++) push(l + 3 * k, 1'b0, 0);
    wait_cyc(l + 7);
    check("t2_rem_free", remaining, 0);
    wait_cyc(l + 13); cmd_abort = 1'b1;
    wait_cyc(l + 14); cmd_abort = 1'b0;
    check("t2_abort_idle", busy, 0);
    wait_cyc(l + 20);
    check("t2_stays_idle", busy, 0);

    // abort coincident with zero status in RUN
    irq_clear = 1'b1; @(posedge clk); #1; irq_clear = 1'b0;
    issue(3, 2, l);
    wait_cyc(l + 5);
    check("t3_status_coincident", cnt_status, 1);
    cmd_abort = 1'b1;
    wait_cyc(l + 6); cmd_abort = 1'b0;
    check("t3_abort_idle", busy, 0);
    check("t3_abort_rem", remaining, 0);
    check("t3_no_expire", expire, 0);
    wait_cyc(l + 7);
    check("t3_irq_unchanged", irq, 0);

    // abort in IDLE ignored with coincident accept, then abort in LOAD
    cmd_abort = 1'b1;
    issue(6, 1, l);
    check("t4_rem_loaded", remaining, 1);
    wait_cyc(l + 1); cmd_abort = 1'b0;
    check("t4_load_abort_idle", busy, 0);
    check("t4_load_abort_rem", remaining, 0);

    // reset mid-RUN overrides everything, then a single-shot N=2
    issue(10, 0, l);
    wait_cyc(l + 6);
    reset = 1'b1; cmd_valid = 1'b1; cmd_abort = 1'b1; cmd_period = 8'd9;
    wait_cyc(l + 7);
    reset = 1'b0; cmd_valid = 1'b0; cmd_abort = 1'b0;
    check_reset_outputs("midrun");
    check("midrun_ready", cmd_ready, 1);
    issue(2, 1, l);
    push(l + 5, 1'b1, 0);
    wait_cyc(l + 6);
    check("t5_done", busy, 0);

    // cmd_valid held during RUN is ignored until IDLE
    issue(4, 1, l);
    push(l + 7, 1'b1, 0);
    wait_cyc(l + 3);
    cmd_period = 8'd7; cmd_repeat = 4'd1; cmd_valid = 1'b1;
    check("t6_ready_in_run", cmd_ready, 0);
    wait_cyc(l + 6);
    check("t6_load_value_held", cnt_load_value, 4);
    wait_cyc(l + 7);
    check("t6_ready_idle", cmd_ready, 1);
    wait_cyc(l + 8); cmd_valid = 1'b0;
    check("t6_reaccepted", busy, 1);
    check("t6_new_load_value", cnt_load_value, 7);
    push(l + 18, 1'b1, 0);
    wait_cyc(l + 19);
    check("t6_done", busy, 0);

    // boundary N = 2^W-1
    issue(255, 2, l);
    push(l + 258, 1'b0, 1); push(l + 516, 1'b1, 0);
    wait_cyc(l + 517);
    check("t7_done", busy, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
